// File: rtl/demux_rr_scheduler.sv
// Routing controller for the 1-to-8 demux tree. Each word is routed either
// round-robin or to an addressed channel, and a watchdog drops addressed words.
module demux_rr_scheduler #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic [2:0]        in_addr,
  input  logic              in_mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        ch_ready,
  output logic [2:0]        sel,
  output logic [DATA_W-1:0] out_data,
  output logic [7:0]        out_valid,
  output logic              drop,
  output logic [CNT_W-1:0]  tx_count
);

  localparam int unsigned WD_W = 8;

  typedef enum logic [1:0] {IDLE, ARB, SEND} state_t;

  state_t            state;
  logic [DATA_W-1:0] hold_data;
  logic [2:0]        hold_addr;
  logic              hold_mode;
  logic [2:0]        last_grant;
  logic [WD_W-1:0]   wd;

  logic       rr_found;
  logic [2:0] rr_win;
  logic [2:0] idx;
  logic       arb_go;
  logic [2:0] arb_ch;

  // Round-robin search starting one past the last grant, wrapping mod 8.
  always_comb begin
    rr_found = 1'b0;
    rr_win   = 3'd0;
    idx      = 3'd0;
    for (int i = 1; i <= 8; i++) begin
      idx = 3'(last_grant + 3'(i));
      if (!rr_found && ch_ready[idx]) begin
        rr_found = 1'b1;
        rr_win   = idx;
      end
    end
  end

  // Grant decision for the word currently held in ARB.
  always_comb begin
    arb_go = 1'b0;
    arb_ch = 3'd0;
    if (hold_mode) begin
      arb_go = ch_ready[hold_addr];
      arb_ch = hold_addr;
    end else begin
      arb_go = rr_found;
      arb_ch = rr_win;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      in_ready   <= 1'b0;
      hold_data  <= '0;
      hold_addr  <= 3'd0;
      hold_mode  <= 1'b0;
      last_grant <= 3'd7;
      wd         <= '0;
      sel        <= 3'd0;
      out_data   <= '0;
      out_valid  <= 8'd0;
      drop       <= 1'b0;
      tx_count   <= '0;
    end else begin
      drop <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            hold_data <= in_data;
            hold_addr <= in_addr;
            hold_mode <= in_mode;
            wd        <= '0;
            in_ready  <= 1'b0;
            state     <= ARB;
          end else begin
            in_ready <= 1'b1;
          end
        end
        ARB: begin
          // A ready channel wins over a watchdog expiring in the same cycle.
          if (arb_go) begin
            sel       <= arb_ch;
            out_valid <= 8'b1 << arb_ch;
            out_data  <= hold_data;
            state     <= SEND;
          end else if (hold_mode) begin
            if (wd == WD_W'(TIMEOUT - 1)) begin
              drop     <= 1'b1;
              wd       <= '0;
              in_ready <= 1'b1;
              state    <= IDLE;
            end else begin
              wd <= wd + WD_W'(1);
            end
          end
        end
        SEND: begin
          if (ch_ready[sel]) begin
            out_valid  <= 8'd0;
            last_grant <= sel;
            tx_count   <= tx_count + CNT_W'(1);
            in_ready   <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_demux_rr_scheduler.sv
// Directed bench for demux_rr_scheduler with hand-computed expectations.
module tb_demux_rr_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic [2:0]  in_addr;
  logic        in_mode;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  ch_ready;
  logic [2:0]  sel;
  logic [7:0]  out_data;
  logic [7:0]  out_valid;
  logic        drop;
  logic [15:0] tx_count;

  int total = 0;
  int bad   = 0;
  int exp_tx = 0;

  demux_rr_scheduler #(.DATA_W(8), .TIMEOUT(15), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_addr(in_addr),
    .in_mode(in_mode), .in_valid(in_valid), .in_ready(in_ready),
    .ch_ready(ch_ready), .sel(sel), .out_data(out_data),
    .out_valid(out_valid), .drop(drop), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for in_ready (bounded), presents one word, returns after the accept edge.
  task automatic accept(input logic [7:0] d, input logic m, input logic [2:0] a);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready), 32'd1);
    in_data  = d;
    in_mode  = m;
    in_addr  = a;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  // Accept with all needed channels ready: checks 2-cycle latency, routing and completion.
  task automatic deliver(input string tag, input logic [7:0] d, input logic m,
                         input logic [2:0] a, input logic [2:0] exp_ch);
    accept(d, m, a);
    chk({tag, "_arb_ov"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_ov"}, 32'(out_valid), 32'(8'b1 << exp_ch));
    chk({tag, "_sel"}, 32'(sel), 32'(exp_ch));
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    tick();
    exp_tx++;
    chk({tag, "_done_ov"}, 32'(out_valid), 32'd0);
    chk({tag, "_tx"}, 32'(tx_count), 32'(exp_tx));
  endtask

  initial begin
    rst_n = 1'b0; in_data = 8'd0; in_addr = 3'd0; in_mode = 1'b0;
    in_valid = 1'b0; ch_ready = 8'hFF;
    #23;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_tx", 32'(tx_count), 32'd0);
    chk("rst_drop", 32'(drop), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rel_in_ready", 32'(in_ready), 32'd1);

    // 1: round-robin over all ready channels
    for (int k = 0; k < 8; k++)
      deliver("rr_all", 8'(8'h11 * (k + 1)), 1'b0, 3'd0, 3'(k));
    chk("rr_all_tx8", 32'(tx_count), 32'd8);

    // 2: sparse round-robin, then stall with no ready channels
    ch_ready = 8'b0010_0100;
    deliver("rr_sp0", 8'h31, 1'b0, 3'd0, 3'd2);
    deliver("rr_sp1", 8'h32, 1'b0, 3'd0, 3'd5);
    deliver("rr_sp2", 8'h33, 1'b0, 3'd0, 3'd2);
    deliver("rr_sp3", 8'h34, 1'b0, 3'd0, 3'd5);
    ch_ready = 8'h00;
    accept(8'h44, 1'b0, 3'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("rr_stall_ready", 32'(in_ready), 32'd0);
      chk("rr_stall_drop", 32'(drop), 32'd0);
      chk("rr_stall_ov", 32'(out_valid), 32'd0);
    end
    ch_ready = 8'h40;
    tick();
    chk("rr_stall_ov6", 32'(out_valid), 32'h40);
    chk("rr_stall_sel6", 32'(sel), 32'd6);
    tick();
    exp_tx++;
    chk("rr_stall_tx", 32'(tx_count), 32'(exp_tx));

    // 3: addressed to ch3, then RR continues from ch4
    ch_ready = 8'hFF;
    deliver("addr3", 8'hA5, 1'b1, 3'd3, 3'd3);
    deliver("rr_after3", 8'h5A, 1'b0, 3'd0, 3'd4);

    // 4: watchdog drop on ch7, then ready arriving on the final ARB cycle
    ch_ready = 8'h7F;
    accept(8'h77, 1'b1, 3'd7);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("wd_drop", 32'(drop), 32'(i == 15));
      chk("wd_ov", 32'(out_valid), 32'd0);
    end
    chk("wd_ready_after", 32'(in_ready), 32'd1);
    chk("wd_tx_same", 32'(tx_count), 32'(exp_tx));
    tick();
    chk("wd_drop_pulse", 32'(drop), 32'd0);
    accept(8'h78, 1'b1, 3'd7);
    for (int i = 1; i <= 14; i++) begin
      tick();
      chk("wd2_drop", 32'(drop), 32'd0);
    end
    ch_ready = 8'hFF;
    tick();
    chk("wd2_drop15", 32'(drop), 32'd0);
    chk("wd2_ov", 32'(out_valid), 32'h80);
    chk("wd2_data", 32'(out_data), 32'h78);
    tick();
    exp_tx++;
    chk("wd2_tx", 32'(tx_count), 32'(exp_tx));
    chk("wd2_drop_end", 32'(drop), 32'd0);

    // 5: backpressure during SEND (last_grant=7, so RR picks ch0)
    accept(8'hC3, 1'b0, 3'd0);
    tick();
    chk("bp_ov", 32'(out_valid), 32'h01);
    ch_ready = 8'hFE;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("bp_hold_ov", 32'(out_valid), 32'h01);
      chk("bp_hold_sel", 32'(sel), 32'd0);
      chk("bp_hold_data", 32'(out_data), 32'hC3);
      chk("bp_hold_tx", 32'(tx_count), 32'(exp_tx));
    end
    ch_ready = 8'hFF;
    tick();
    exp_tx++;
    chk("bp_done_ov", 32'(out_valid), 32'd0);
    chk("bp_done_tx", 32'(tx_count), 32'(exp_tx));

    // 6: async reset mid-SEND, then capture isolation of mode/addr
    ch_ready = 8'hFD;
    deliver("pre_rst", 8'h99, 1'b0, 3'd0, 3'd1 - 3'd1 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd0 + 3'd2);
    ch_ready = 8'h00;
    accept(8'hEE, 1'b1, 3'd4);
    ch_ready = 8'h10;
    tick();
    chk("mid_ov", 32'(out_valid), 32'h10);
    ch_ready = 8'h00;
    #2;
    rst_n = 1'b0;
    #1;
    exp_tx = 0;
    chk("arst_ov", 32'(out_valid), 32'd0);
    chk("arst_tx", 32'(tx_count), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd0);
    chk("arst_sel", 32'(sel), 32'd0);
    tick();
    rst_n = 1'b1;
    ch_ready = 8'hFF;
    accept(8'h3C, 1'b1, 3'd2);
    in_mode = 1'b0;
    in_addr = 3'd5;
    tick();
    chk("iso_ov", 32'(out_valid), 32'h04);
    chk("iso_sel", 32'(sel), 32'd2);
    tick();
    exp_tx++;
    chk("iso_tx", 32'(tx_count), 32'(exp_tx));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Controller in front of the 1-to-8 demultiplexer tree: accepts words on a valid/ready input port and decides which of 8 output channels receives each word.
- Drives the 3-bit channel select and the data for the demux.
- Two routing modes, captured per word:
  - Round-robin: next ready channel after the last grant.
  - Addressed: channel given with the word.
- A watchdog drops addressed words whose channel never becomes ready.

Parameters:
DATA_W, 8, width of the routed data word
TIMEOUT, 15, cycles to wait in addressed mode before dropping the word (1..255)
CNT_W, 16, width of the delivered-word counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_data  input  DATA_W  word to route
in_addr  input  3  destination channel, used only when in_mode=1
in_mode  input  1  0 = round-robin, 1 = addressed
in_valid  input  1  word present
in_ready  output  1  scheduler can accept a word
ch_ready  input  8  per-channel consumer ready, bit k = channel k
sel  output  3  channel select to demux (bit 2 = first stage, bit 0 = last stage)
out_data  output  DATA_W  word presented to demux input
out_valid  output  8  one-hot strobe, bit k = channel k receiving
drop  output  1  one-cycle pulse when a word is discarded by watchdog
tx_count  output  CNT_W  number of words delivered since reset, wraps

Behaviour:
- Reset (async, rst_n=0): state=IDLE; in_ready=0 while rst_n low, 1 from first clock after release; sel=0; out_data=0; out_valid=0; drop=0; tx_count=0; last_grant=7, so first RR grant searches from channel 0; watchdog=0.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: capture in_data, in_addr, in_mode into a holding register; go to ARB.
  - in_ready=0 in every other state; one-word buffer, no skid.
- ARB:
  - RR mode: search ch_ready from last_grant+1 upward mod 8; first set bit wins, register sel=winner, go to SEND.
    - If ch_ready=0, stay in ARB indefinitely; no timeout in RR mode.
  - Addressed mode: if ch_ready[addr]=1, set sel=addr and go to SEND.
    - Otherwise increment watchdog.
    - When watchdog reaches TIMEOUT: pulse drop for 1 cycle, clear watchdog, discard word, go to IDLE. last_grant and tx_count are unchanged.
  - Watchdog clears on entering ARB.
- SEND:
  - out_data=held word; out_valid[sel]=1, all other bits 0.
  - Transfer completes in any SEND cycle with ch_ready[sel]=1. On completion: last_grant=sel (both modes); tx_count+1, wrapping at 2^CNT_W; go to IDLE; out_valid=0 next cycle.
  - If ch_ready[sel] drops, hold out_valid, sel and data stable until it returns. No re-arbitration and no timeout in SEND.
- Latency: accept at cycle N, ARB at N+1, out_valid high at N+2 if channel ready; next accept at N+3 earliest. Peak throughput is 1 word per 3 cycles.
- sel changes only on the ARB->SEND transition; it holds its value in IDLE. out_data holds its value when out_valid=0.
- in_mode and in_addr are sampled only at capture; later changes do not affect the word in flight.
- Simultaneous events:
  - Timeout and channel becoming ready in the same ARB cycle: ready wins, word delivered, no drop.
  - Reset asserted mid-SEND: word lost, all outputs go to reset values immediately.

Test Plan:
1. Reset release, ch_ready=8'hFF, send 0x11,0x22,...,0x88 in RR mode -> out_valid one-hot 0x01,0x02,...,0x80 in order; sel 0..7; tx_count=8; each out_valid exactly 2 cycles after its accept.
2. RR with ch_ready=8'b0010_0100, 4 words -> grants alternate ch2, ch5, ch2, ch5. Then ch_ready=0 for 10 cycles -> stays in ARB, in_ready=0, no drop; set ch_ready[6] -> delivered to ch6.
3. Addressed mode, in_addr=3, data 0xA5, ch_ready[3]=1 -> out_valid=8'h08, sel=3, out_data=0xA5; last_grant=3, so the next RR word with all ready goes to ch4.
4. Addressed mode, in_addr=7, ch_ready[7]=0 with TIMEOUT=15 -> drop pulses exactly once, 15 ARB cycles after entering ARB; tx_count unchanged; in_ready=1 the following cycle. Repeat with ch_ready[7] rising on the 15th ARB cycle -> delivered, no drop.
5. SEND with ch_ready[sel] lowered for 4 cycles -> out_valid, sel and out_data stable for all 4 cycles; completes on the first cycle ready returns.
6. Assert rst_n=0 during SEND -> out_valid=0 and tx_count=0 asynchronously. Change in_mode/in_addr after capture -> routing unaffected.
